// File: rtl/led_pattern_ctrl_if.sv
// Purpose: per-channel configuration write bus for led_pattern_ctrl.
// Latency: none (wires only).
// Backpressure: none; every strobed write is accepted in the cycle it is presented.
// Signals: cfg_we write strobe, cfg_ch channel index, cfg_mode mode,
//          cfg_duty PWM brightness, cfg_period half-period / step interval in ticks.
// master drives the bus (control logic), slave receives it (led_pattern_ctrl).
interface led_pattern_ctrl_if #(
    parameter int PWM_BITS = 8
);
    logic                cfg_we;
    logic [3:0]          cfg_ch;
    logic [1:0]          cfg_mode;
    logic [PWM_BITS-1:0] cfg_duty;
    logic [15:0]         cfg_period;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_mode,
        output cfg_duty,
        output cfg_period
    );

    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_mode,
        input cfg_duty,
        input cfg_period
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// Purpose: multi-channel LED driver with OFF/ON/BLINK/BREATHE modes and PWM brightness.
// Latency: config write sampled at edge T is visible on led at edge T+1; led is registered.
// Backpressure: none; writes are always accepted, writes to cfg_ch >= CH_NUM are dropped.
// Ports: clk, rst (synchronous, active-high), cfg (led_pattern_ctrl_if slave), led[CH_NUM-1:0].
// Optional macro LED_BREATHE_EN: when defined, BREATHE ramps its level up and down;
// when undefined, no level/direction state is built and mode 3 behaves exactly like ON.
module led_pattern_ctrl #(
    parameter int CH_NUM      = 4,
    parameter int CLK_FREQ_HZ = 25000000,
    parameter int TICK_HZ     = 1000,
    parameter int PWM_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pattern_ctrl_if.slave    cfg,
    output logic [CH_NUM-1:0]    led
);
    localparam int PRESC_TC = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int PRESC_W  = (PRESC_TC > 0) ? $clog2(PRESC_TC + 1) : 1;
    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    // Duty all-ones is forced lit so full brightness has no one-cycle gap per PWM frame.
    function automatic logic pwm_on(input logic [PWM_BITS-1:0] cnt,
                                    input logic [PWM_BITS-1:0] x);
        return (cnt < x) || (x == PWM_MAX);
    endfunction

    logic [PRESC_W-1:0]  presc;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [CH_NUM-1:0]   led_nxt_vec;

    assign tick = (presc == PRESC_W'(PRESC_TC));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
            led     <= '0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            led     <= led_nxt_vec;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        mode_t               mode_q;
        logic [PWM_BITS-1:0] duty_q;
        logic [15:0]         period_q;
        logic [15:0]         tcnt_q;
        logic                phase_q;
        logic                wr_hit;
        logic                timed;
        logic                wrap;
        logic [15:0]         eff_period;
        logic                led_nxt;

        // Only indices below CH_NUM have a generate instance, so out-of-range writes hit nothing.
        assign wr_hit     = cfg.cfg_we && (cfg.cfg_ch == 4'(c));
        assign eff_period = (period_q == 16'd0) ? 16'd1 : period_q;
`ifdef LED_BREATHE_EN
        assign timed = (mode_q == MODE_BLINK) || (mode_q == MODE_BREATHE);
`else
        assign timed = (mode_q == MODE_BLINK);
`endif
        assign wrap = tick && timed && (tcnt_q >= eff_period - 16'd1);

        // A write restarts the pattern and takes priority over a coincident tick.
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q   <= MODE_OFF;
                duty_q   <= '1;
                period_q <= 16'd500;
                tcnt_q   <= '0;
                phase_q  <= 1'b0;
            end else if (wr_hit) begin
                mode_q   <= mode_t'(cfg.cfg_mode);
                duty_q   <= cfg.cfg_duty;
                period_q <= cfg.cfg_period;
                tcnt_q   <= '0;
                phase_q  <= 1'b1;
            end else if (wrap) begin
                tcnt_q   <= '0;
                phase_q  <= ~phase_q;
            end else if (tick && timed) begin
                tcnt_q   <= tcnt_q + 16'd1;
            end
        end

`ifdef LED_BREATHE_EN
        logic [PWM_BITS-1:0] level_q;
        logic [PWM_BITS-1:0] level_step;
        logic                dir_up_q;

        assign level_step = dir_up_q ? level_q + 1'b1 : level_q - 1'b1;

        // Direction flips on arriving at either extreme, so the level never wraps.
        always_ff @(posedge clk) begin
            if (rst || wr_hit) begin
                level_q  <= '0;
                dir_up_q <= 1'b1;
            end else if (wrap && (mode_q == MODE_BREATHE)) begin
                level_q <= level_step;
                if ((level_step == PWM_MAX) || (level_step == '0)) begin
                    dir_up_q <= ~dir_up_q;
                end
            end
        end
`endif

        always_comb begin
            led_nxt = 1'b0;
            case (mode_q)
                MODE_OFF:     led_nxt = 1'b0;
                MODE_ON:      led_nxt = pwm_on(pwm_cnt, duty_q);
                MODE_BLINK:   led_nxt = phase_q && pwm_on(pwm_cnt, duty_q);
`ifdef LED_BREATHE_EN
                MODE_BREATHE: led_nxt = pwm_on(pwm_cnt, level_q);
`else
                MODE_BREATHE: led_nxt = pwm_on(pwm_cnt, duty_q);
`endif
                default:      led_nxt = 1'b0;
            endcase
        end

        assign led_nxt_vec[c] = led_nxt;
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Purpose: randomized scoreboard bench for led_pattern_ctrl with a closed-form reference model.
// Latency: expected led pushed at each rising edge, compared on the following falling edge.
// Backpressure: n/a (bench).
module tb_led_pattern_ctrl;
    localparam int CH  = 4;
    localparam int TPC = 10;   // clk per tick: 1000 Hz / 100 Hz

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] led;

    led_pattern_ctrl_if #(.PWM_BITS(8)) bus();

    led_pattern_ctrl #(
        .CH_NUM(CH),
        .CLK_FREQ_HZ(1000),
        .TICK_HZ(100),
        .PWM_BITS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(bus),
        .led(led)
    );

    always #5 clk = ~clk;

    // Model state: configuration of each channel and the edge index at which it was written.
    int m_mode [CH];
    int m_duty [CH];
    int m_per  [CH];
    int m_w    [CH];
    int cyc;
    logic [CH-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic bit pon(int pc, int x);
        return (pc < x) || (x == 255);
    endfunction

    // Expected led for channel c at non-reset edge n, from elapsed ticks since the write.
    function automatic bit exp_bit(int c, int n);
        int pc, t, eff, k, lvl;
        pc  = (n - 1) % 256;
        t   = (n - 1) / TPC - m_w[c] / TPC;
        eff = (m_per[c] == 0) ? 1 : m_per[c];
        k   = t / eff;
        lvl = 0;
        case (m_mode[c])
            1: return pon(pc, m_duty[c]);
            2: return ((k % 2) == 0) && pon(pc, m_duty[c]);
            3: begin
`ifdef LED_BREATHE_EN
                lvl = k % 510;
                if (lvl > 255) lvl = 510 - lvl;
                return pon(pc, lvl);
`else
                return pon(pc, m_duty[c]);
`endif
            end
            default: return 1'b0;
        endcase
    endfunction

    logic [CH-1:0] m_exp;
    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            for (int c = 0; c < CH; c++) begin
                m_mode[c] = 0;
                m_duty[c] = 255;
                m_per[c]  = 500;
                m_w[c]    = 0;
            end
            m_exp = '0;
        end else begin
            cyc = cyc + 1;
            for (int c = 0; c < CH; c++) m_exp[c] = exp_bit(c, cyc);
            if (bus.cfg_we && (int'(bus.cfg_ch) < CH)) begin
                m_mode[bus.cfg_ch] = int'(bus.cfg_mode);
                m_duty[bus.cfg_ch] = int'(bus.cfg_duty);
                m_per[bus.cfg_ch]  = int'(bus.cfg_period);
                m_w[bus.cfg_ch]    = cyc;
            end
        end
        exp_q.push_back(m_exp);
    end

    logic [CH-1:0] mon_exp;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            n_cmp++;
            if (led !== mon_exp) begin
                n_bad++;
                $display("FAIL led t=%0t edge=%0d got=%b want=%b", $time, cyc, led, mon_exp);
            end
        end
    end

    task automatic idle(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wr(int ch, int mode, int duty, int per);
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 4'(ch);
        bus.cfg_mode   = 2'(mode);
        bus.cfg_duty   = 8'(duty);
        bus.cfg_period = 16'(per);
        @(negedge clk);
        bus.cfg_we     = 1'b0;
    endtask

    initial begin
        // Reset held with a write pending: the write must not survive.
        rst            = 1'b1;
        bus.cfg_we     = 1'b1;
        bus.cfg_ch     = 4'd0;
        bus.cfg_mode   = 2'd1;
        bus.cfg_duty   = 8'hFF;
        bus.cfg_period = 16'd500;
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        bus.cfg_we = 1'b0;
        idle(20);

        wr(1, 1, 8'hFF, 500);  idle(300);
        wr(1, 1, 8'h40, 500);  idle(600);
        wr(2, 2, 8'hFF, 3);    idle(200);
        wr(2, 2, 8'hFF, 0);    idle(100);

        // Align the next write with a tick edge.
        for (int i = 0; i < TPC && (cyc % TPC) != TPC - 1; i++) @(negedge clk);
        if ((cyc % TPC) != TPC - 1) begin
            n_bad++;
            $display("FAIL tick_align got=%0d want=%0d", cyc % TPC, TPC - 1);
        end
        wr(2, 2, 8'hFF, 3);    idle(150);

        wr(3, 3, 8'h80, 1);    idle(5400);
        wr(7, 1, 8'hFF, 1);    idle(50);
        wr(15, 0, 8'h00, 0);   idle(30);

        repeat (30) begin
            wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 255),
               $urandom_range(0, 4));
            idle($urandom_range(1, 300));
        end

        // Mid-pattern reset with a coincident write.
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 4'd1;
        bus.cfg_mode = 2'd1;
        bus.cfg_duty = 8'hFF;
        rst          = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        bus.cfg_we = 1'b0;
        idle(100);

        repeat (10) begin
            wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255),
               $urandom_range(0, 3));
            idle($urandom_range(20, 200));
        end
        idle(3);

        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL compare_count got=%0d want>=12", n_cmp);
        end
        if (exp_q.size() > 1) begin
            n_bad++;
            $display("FAIL queue_drain got=%0d want<=1", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised multi-channel LED driver; successor to the single free-running blink counter.
- Each channel is independently configurable through a simple write port to one of four modes: OFF, ON, BLINK, BREATHE.
- Brightness is set by an 8-bit PWM duty.
- Sits between board-level LED pins and any control logic: a test FSM, a status monitor, or a host register bank.

Parameters:
CH_NUM, 4, number of LED channels (1..16)
CLK_FREQ_HZ, 25000000, input clock frequency
TICK_HZ, 1000, timebase tick rate; prescaler terminal count = CLK_FREQ_HZ/TICK_HZ - 1
PWM_BITS, 8, PWM duty/level resolution

Ports:
clk  input  1  system clock, 25 MHz nominal
rst  input  1  synchronous reset, active-high
cfg_we  input  1  single-cycle config write strobe
cfg_ch  input  4  target channel index; values >= CH_NUM ignored
cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BREATHE
cfg_duty  input  PWM_BITS  brightness for ON/BLINK
cfg_period  input  16  BLINK half-period / BREATHE step interval, in ticks
led  output  CH_NUM  LED drive, 1 = lit, registered

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on rising clk.
- Reset state:
  - led=0; all modes OFF; duty=all-ones; period=500.
  - Prescaler, PWM counter, per-channel tick counters, phase and level all 0; breathe direction = up.
- Prescaler counts 0..CLK_FREQ_HZ/TICK_HZ-1 and wraps.
  - tick = 1 for exactly one cycle at terminal count.
- PWM counter: PWM_BITS wide, free-running, +1 every clk, wraps at 2^PWM_BITS-1 -> 0.
- pwm_on(x) = (pwm_cnt < x) OR (x == all-ones).
  - x=0 gives always dark; all-ones gives always lit.
- Per-channel modes:
  - OFF: led_next=0.
  - ON: led_next=pwm_on(duty).
  - BLINK:
    - On tick, tick counter +1.
    - When counter reaches eff_period-1: counter->0, phase toggles.
    - led_next = phase AND pwm_on(duty).
  - BREATHE:
    - On tick, counter +1; at eff_period-1 counter->0 and level steps by 1 in the current direction.
    - Direction reverses when level reaches all-ones (up) or 0 (down). Level saturates and never wraps.
    - led_next = pwm_on(level).
  - eff_period = cfg_period, with 0 treated as 1.
- Config write:
  - On cfg_we with cfg_ch < CH_NUM: mode/duty/period of that channel load at the next edge.
  - Tick counter->0, phase->1 (lit), level->0, direction->up.
  - Other channels are unaffected.
  - Latency: write sampled at edge T; led reflects new config at edge T+1 (led registered from combinational led_next).
- Simultaneous cfg_we and tick on same channel: config wins; that tick is not counted for that channel.
- Rewriting identical config still restarts that channel's pattern.
- rst asserted mid-pattern returns everything to reset state at that edge, regardless of cfg_we.
- No combinational path from any input to led.

Optional Feature:
LED_BREATHE_EN:
- Defined: BREATHE mode implemented as above.
- Not defined:
  - Level/direction registers are not built.
  - cfg_mode=3 behaves exactly as ON (pwm_on(duty)).
  - No other behaviour changes.

Test Plan:
- Sim parameters: CLK_FREQ_HZ=1000, TICK_HZ=100 (10 clk/tick), PWM_BITS=8.
- Reset: hold rst 3 cycles with cfg_we=1, ch0 mode=1 -> led=0 all channels; the write is ignored after release.
- ON: write ch1, mode=1, duty=8'hFF -> led[1]=1 constantly from the second edge after the write. Duty=8'h40 -> led[1] high exactly 64 of every 256 cycles.
- BLINK: write ch2, mode=2, duty=FF, period=3 -> led[2] high 30 clk, low 30 clk, repeating. Period=0 -> toggles every 10 clk.
- BREATHE (LED_BREATHE_EN defined): write ch3, mode=3, period=1 -> level 0->255 over 2550 clk, then 255->0, with no wrap. Undefined -> behaves as ON with the written duty.
- Collision/range:
  - Write ch2 on the same cycle as tick -> counter restarts at 0 and the first toggle comes 30 clk later.
  - Write with cfg_ch=7 (CH_NUM=4) -> no led change.
